// File: rtl/uart_pkt_deframer_if.sv
// uart_pkt_deframer_if: byte-in / AXI-stream-out bundle of the host-link deframer.
// master = deframer side, slave = byte source / stream sink side.
interface uart_pkt_deframer_if #(
  parameter int DATA_WIDTH = 64
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   m_tdata;
  logic [DATA_WIDTH/8-1:0] m_tkeep;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic [7:0]              m_tuser_type;
  logic                    m_tuser_err;
  logic                    stat_ok;
  logic                    stat_err_crc;
  logic                    stat_err_len;
  logic                    stat_err_timeout;

  modport master (
    input  in_data, in_valid, m_tready,
    output in_ready,
    output m_tdata, m_tkeep, m_tvalid, m_tlast,
    output m_tuser_type, m_tuser_err,
    output stat_ok, stat_err_crc,
    output stat_err_len, stat_err_timeout
  );

  modport slave (
    output in_data, in_valid, m_tready,
    input  in_ready,
    input  m_tdata, m_tkeep, m_tvalid, m_tlast,
    input  m_tuser_type, m_tuser_err,
    input  stat_ok, stat_err_crc,
    input  stat_err_len, stat_err_timeout
  );
endinterface

// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: parses 5A|type|len|payload|crc frames into AXI-stream beats.
// Define UART_PKT_CRC_CHECK_EN to compute and check the CRC-16/CCITT-FALSE trailer.
module uart_pkt_deframer #(
  parameter int         DATA_WIDTH   = 64,
  parameter int         MAX_LEN      = 1518,
  parameter logic [7:0] START_BYTE   = 8'h5A,
  parameter int         IDLE_TIMEOUT = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_pkt_deframer_if.master bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(BYTES + 1);
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_LANE = AW'(BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    HUNT, TYPE, LEN_HI, LEN_LO,
    PAYLOAD, CRC_HI, CRC_LO, FLUSH
  } state_t;

  state_t                state;
  logic [7:0]            type_q;
  logic [7:0]            len_hi_q;
  logic [15:0]           len_q;
  logic [15:0]           byte_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [AW-1:0]         acc_n;
  logic [BYTES-1:0]      keep_last;
  logic [TW-1:0]         timer;
  logic                  hold_v;
  logic                  err_q;
  logic                  fin_ok;
  logic                  fin_crc;

  logic        accept;
  logic        out_free;
  logic        last_byte;
  logic        need_out;
  logic        timing;
  logic        timeout;
  logic        crc_bad;
  logic [15:0] len_nxt;

  assign out_free  = !bus.m_tvalid || bus.m_tready;
  assign last_byte = byte_cnt == len_q - 16'd1;
  assign need_out  = state == PAYLOAD
                  && acc_n == LAST_LANE
                  && !last_byte;
  assign bus.in_ready = state != FLUSH
                     && !(need_out && !out_free);
  assign accept  = bus.in_valid && bus.in_ready;
  assign timing  = state != HUNT && state != FLUSH;
  assign timeout = timing && bus.in_ready
                && !bus.in_valid
                && timer == TO_LAST;
  assign len_nxt = {len_hi_q, bus.in_data};

  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < BYTES; i++)
      if (acc_n == AW'(i))
        acc_nxt[i*8 +: 8] = bus.in_data;
  end

  always_comb begin
    keep_last = '0;
    for (int i = 0; i < BYTES; i++)
      keep_last[i] = AW'(i) < acc_n;
  end

`ifdef UART_PKT_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_hi_q;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q    <= 16'hFFFF;
      crc_hi_q <= '0;
    end else if (accept) begin
      unique case (state)
        HUNT:    crc_q <= 16'hFFFF;
        TYPE,
        LEN_HI,
        LEN_LO,
        PAYLOAD: crc_q <= crc_step(crc_q, bus.in_data);
        CRC_HI:  crc_hi_q <= bus.in_data;
        default: ;
      endcase
    end
  end

  assign crc_bad = {crc_hi_q, bus.in_data} != crc_q;
`else
  assign crc_bad = 1'b0;
`endif

  // idle cycles only; stalls from in_ready=0 are not the sender's fault
  always_ff @(posedge clk) begin
    if (!rst_n || !timing || accept)
      timer <= '0;
    else if (bus.in_ready)
      timer <= timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= HUNT;
      type_q               <= '0;
      len_hi_q             <= '0;
      len_q                <= '0;
      byte_cnt             <= '0;
      acc                  <= '0;
      acc_n                <= '0;
      hold_v               <= 1'b0;
      err_q                <= 1'b0;
      fin_ok               <= 1'b0;
      fin_crc              <= 1'b0;
      bus.m_tdata          <= '0;
      bus.m_tkeep          <= '0;
      bus.m_tvalid         <= 1'b0;
      bus.m_tlast          <= 1'b0;
      bus.m_tuser_type     <= '0;
      bus.m_tuser_err      <= 1'b0;
      bus.stat_ok          <= 1'b0;
      bus.stat_err_crc     <= 1'b0;
      bus.stat_err_len     <= 1'b0;
      bus.stat_err_timeout <= 1'b0;
    end else begin
      bus.stat_ok          <= 1'b0;
      bus.stat_err_crc     <= 1'b0;
      bus.stat_err_len     <= 1'b0;
      bus.stat_err_timeout <= 1'b0;
      if (bus.m_tvalid && bus.m_tready)
        bus.m_tvalid <= 1'b0;

      if (timeout) begin
        bus.stat_err_timeout <= 1'b1;
        hold_v  <= byte_cnt != 16'd0;
        err_q   <= 1'b1;
        fin_ok  <= 1'b0;
        fin_crc <= 1'b0;
        state   <= (byte_cnt != 16'd0) ? FLUSH : HUNT;
      end else if (accept) begin
        unique case (state)
          HUNT: begin
            if (bus.in_data == START_BYTE) begin
              byte_cnt <= '0;
              acc      <= '0;
              acc_n    <= '0;
              state    <= TYPE;
            end
          end
          TYPE: begin
            type_q <= bus.in_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            len_hi_q <= bus.in_data;
            state    <= LEN_LO;
          end
          LEN_LO: begin
            len_q <= len_nxt;
            if (len_nxt > 16'(MAX_LEN)) begin
              bus.stat_err_len <= 1'b1;
              state <= HUNT;
            end else if (len_nxt == 16'd0) begin
              state <= CRC_HI;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            byte_cnt <= byte_cnt + 16'd1;
            if (last_byte) begin
              // final beat stays in acc until the CRC verdict
              acc   <= acc_nxt;
              acc_n <= acc_n + AW'(1);
              state <= CRC_HI;
            end else if (acc_n == LAST_LANE) begin
              bus.m_tdata      <= acc_nxt;
              bus.m_tkeep      <= '1;
              bus.m_tlast      <= 1'b0;
              bus.m_tuser_err  <= 1'b0;
              bus.m_tuser_type <= type_q;
              bus.m_tvalid     <= 1'b1;
              acc   <= '0;
              acc_n <= '0;
            end else begin
              acc   <= acc_nxt;
              acc_n <= acc_n + AW'(1);
            end
          end
          CRC_HI: state <= CRC_LO;
          CRC_LO: begin
            if (len_q == 16'd0) begin
              bus.stat_ok      <= !crc_bad;
              bus.stat_err_crc <= crc_bad;
              state <= HUNT;
            end else begin
              hold_v  <= 1'b1;
              err_q   <= crc_bad;
              fin_ok  <= !crc_bad;
              fin_crc <= crc_bad;
              state   <= FLUSH;
            end
          end
          default: ;
        endcase
      end else if (state == FLUSH) begin
        if (hold_v) begin
          if (out_free) begin
            bus.m_tdata      <= acc;
            bus.m_tkeep      <= keep_last;
            bus.m_tlast      <= 1'b1;
            bus.m_tuser_err  <= err_q;
            bus.m_tuser_type <= type_q;
            bus.m_tvalid     <= 1'b1;
            hold_v <= 1'b0;
          end
        end else if (bus.m_tvalid && bus.m_tready) begin
          bus.stat_ok      <= fin_ok;
          bus.stat_err_crc <= fin_crc;
          state <= HUNT;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_pkt_deframer.sv
// tb_uart_pkt_deframer: randomized scoreboard bench for uart_pkt_deframer.
// Frames and CRCs come from a queue-based model; a monitor pops expected beats/stats.
module tb_uart_pkt_deframer;
  localparam int DW = 64;
  localparam int TO = 300;
  localparam int ST_OK  = 1;
  localparam int ST_CRC = 2;
  localparam int ST_LEN = 3;
  localparam int ST_TO  = 4;
`ifdef UART_PKT_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_pkt_deframer_if #(.DATA_WIDTH(DW)) bus ();

  uart_pkt_deframer #(
    .DATA_WIDTH(DW),
    .MAX_LEN(1518),
    .START_BYTE(8'h5A),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  typ;
    logic        err;
  } beat_t;

  beat_t      beat_q[$];
  int         stat_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] frm_q[$];
  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC-16/CCITT-FALSE, bit-serial form
  task automatic build_frame(input logic [7:0] typ, input bit bad);
    logic [15:0] crc;
    logic [15:0] len;
    logic [7:0]  body[$];
    logic        fb;
    crc = 16'hFFFF;
    len = 16'(pay_q.size());
    body = {};
    body.push_back(typ);
    body.push_back(len[15:8]);
    body.push_back(len[7:0]);
    foreach (pay_q[i]) body.push_back(pay_q[i]);
    foreach (body[i])
      for (int j = 7; j >= 0; j--) begin
        fb  = crc[15] ^ body[i][j];
        crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    frm_q = {};
    frm_q.push_back(8'h5A);
    foreach (body[i]) frm_q.push_back(body[i]);
    frm_q.push_back(crc[15:8]);
    frm_q.push_back(crc[7:0] ^ {7'd0, bad});
  endtask

  task automatic expect_beats(input logic [7:0] typ, input int n,
                              input bit err);
    int nb;
    beat_t e;
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int k = 0; k < 8; k++)
        if (b * 8 + k < n) begin
          e.data[k*8 +: 8] = pay_q[b*8+k];
          e.keep[k] = 1'b1;
        end
      e.last = (b == nb - 1);
      e.typ  = typ;
      e.err  = e.last && err;
      beat_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stall_cnt++;
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_wait: got 0 for 5000 cycles expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int cnt, input int gap_max);
    int g;
    for (int i = 0; i < cnt; i++) begin
      send_byte(frm_q[i]);
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] typ, input bit bad,
                           input int gap_max);
    bit eb;
    eb = bad && CRC_EN;
    build_frame(typ, bad);
    if (pay_q.size() > 0) expect_beats(typ, pay_q.size(), eb);
    stat_q.push_back(eb ? ST_CRC : ST_OK);
    send_bytes(frm_q.size(), gap_max);
  endtask

  task automatic rand_payload(input int n);
    pay_q = {};
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic ramp_payload(input int n);
    pay_q = {};
    for (int i = 0; i < n; i++) pay_q.push_back(8'(i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((beat_q.size() != 0 || stat_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_beats", 64'(beat_q.size()), 64'd0);
    chk("drain_stats", 64'(stat_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t       e;
    logic [63:0] m;
    int          code;
    if (rst_n) begin
      if (bus.m_tvalid && bus.m_tready) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected none",
                   bus.m_tdata);
        end else begin
          e = beat_q.pop_front();
          m = '0;
          for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{e.keep[k]}};
          chk("tdata", bus.m_tdata & m, e.data);
          chk("tkeep", 64'(bus.m_tkeep), 64'(e.keep));
          chk("tlast", 64'(bus.m_tlast), 64'(e.last));
          chk("tuser_type", 64'(bus.m_tuser_type), 64'(e.typ));
          if (e.last) chk("tuser_err", 64'(bus.m_tuser_err), 64'(e.err));
        end
      end
      code = bus.stat_ok ? ST_OK :
             bus.stat_err_crc ? ST_CRC :
             bus.stat_err_len ? ST_LEN :
             bus.stat_err_timeout ? ST_TO : 0;
      if (code != 0) begin
        if (stat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stat: got %0d expected none", code);
        end else begin
          chk("stat", 64'(code), 64'(stat_q.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.m_tready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_tdata", bus.m_tdata, 64'd0);
    chk("rst_tkeep", 64'(bus.m_tkeep), 64'd0);
    chk("rst_tlast_err_type",
        64'({bus.m_tlast, bus.m_tuser_err, bus.m_tuser_type}), 64'd0);
    chk("rst_stats", 64'({bus.stat_ok, bus.stat_err_crc,
                          bus.stat_err_len, bus.stat_err_timeout}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pay_q = {8'h00, 8'h01};
    run_frame(8'h01, 1'b0, 0);
    drain();

    ramp_payload(70);
    run_frame(8'h10, 1'b0, 1);
    drain();

    ramp_payload(70);
    run_frame(8'h10, 1'b1, 0);
    drain();

    frm_q = {8'h11, 8'h22, 8'h5A, 8'h10, 8'h06, 8'h00};
    stat_q.push_back(ST_LEN);
    send_bytes(6, 0);
    rand_payload(5);
    run_frame(8'h33, 1'b0, 2);
    drain();

    pay_q = {};
    run_frame(8'h07, 1'b0, 0);
    drain();

    pay_q = {8'h5A, 8'h5A, 8'h01, 8'h5A, 8'hA5};
    run_frame(8'h5A, 1'b0, 1);
    drain();

    rand_payload(16);
    build_frame(8'h22, 1'b0);
    expect_beats(8'h22, 12, 1'b1);
    stat_q.push_back(ST_TO);
    send_bytes(4 + 12, 0);
    repeat (TO + 20) @(posedge clk);
    #1;
    chk("to_in_ready", 64'(bus.in_ready), 64'd1);
    drain();
    rand_payload(9);
    run_frame(8'h44, 1'b0, 0);
    drain();

    rnd_rdy   = 1'b1;
    stall_cnt = 0;
    ramp_payload(70);
    run_frame(8'h10, 1'b0, 0);
    ramp_payload(70);
    run_frame(8'h11, 1'b1, 0);
    for (int f = 0; f < 6; f++) begin
      rand_payload($urandom_range(1, 40));
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 2);
    end
    drain();
    rnd_rdy = 1'b0;
    chk("stall_seen", 64'(stall_cnt > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
